// File: rtl/z80_bus_ctrl.sv
// rtl/z80_bus_ctrl.sv - Z80 bus-cycle classifier, wait-state inserter and strobe generator
// Ports:
//   eclk, erst            system clock, synchronous active-high reset
//   cpu_clk               Z80 clock level, sampled in the eclk domain
//   _mreq _iorq _m1 _rfsh _wr ab   Z80 bus (controls active low)
//   _wait                 to Z80 WAIT pad, active low
//   ram_wr                one-eclk RAM write pulse
//   _uart_cs              one-eclk UART select pulse, active low
//   dsel                  read source: 0 RAM, 1 UART, 2 const 0xBF, 3 INTA vector 0xFF
//   busy                  high while a non-refresh cycle is in progress
module z80_bus_ctrl #(
  parameter logic [6:0]  UART_BASE = 7'h55,
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned IO_WAIT   = 0
) (
  input  logic        eclk,
  input  logic        erst,
  input  logic        cpu_clk,
  input  logic        _mreq,
  input  logic        _iorq,
  input  logic        _m1,
  input  logic        _rfsh,
  input  logic        _wr,
  input  logic [15:0] ab,
  output logic        _wait,
  output logic        ram_wr,
  output logic        _uart_cs,
  output logic [1:0]  dsel,
  output logic        busy
);

  typedef enum logic [2:0] {ST_IDLE, ST_MEM, ST_IO, ST_INTA, ST_END} state_t;

  localparam logic [3:0] MEM_WC = 4'(MEM_WAIT);
  localparam logic [3:0] IO_WC  = 4'(IO_WAIT);

  state_t     state;
  logic [3:0] wcnt;
  logic       last_clk;
  logic       rise;
  logic       uart_hit;
  logic       bus_idle;
  logic       unused_ab;

  assign rise      = cpu_clk & ~last_clk;
  assign uart_hit  = (ab[7:1] == UART_BASE);
  assign bus_idle  = _mreq & _iorq;
  assign unused_ab = ^{ab[15:8], ab[0]};

  always_ff @(posedge eclk) begin
    if (erst) begin
      state    <= ST_IDLE;
      wcnt     <= 4'd0;
      last_clk <= 1'b0;
      _wait    <= 1'b1;
      ram_wr   <= 1'b0;
      _uart_cs <= 1'b1;
      dsel     <= 2'd0;
      busy     <= 1'b0;
    end else begin
      last_clk <= cpu_clk;
      // strobes are single-eclk: cleared every cycle unless re-armed below
      ram_wr   <= 1'b0;
      _uart_cs <= 1'b1;

      if (_iorq)         dsel <= 2'd0;
      else if (!_m1)     dsel <= 2'd3;
      else if (uart_hit) dsel <= 2'd1;
      else               dsel <= 2'd2;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            // memory wins over IO; a refresh cycle leaves us idle
            if (!_mreq) begin
              if (_rfsh) begin
                state <= ST_MEM;
                busy  <= 1'b1;
                wcnt  <= MEM_WC;
                _wait <= (MEM_WC == 4'd0);
              end
            end else if (!_iorq) begin
              busy <= 1'b1;
              if (_m1) begin
                state <= ST_IO;
                if (uart_hit) begin
                  wcnt  <= IO_WC;
                  _wait <= (IO_WC == 4'd0);
                end else begin
                  wcnt <= 4'd0;
                end
              end else begin
                state <= ST_INTA;
                wcnt  <= 4'd0;
              end
            end
          end
        end

        ST_END: begin
          if (bus_idle) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          if (bus_idle) begin
            // CPU abandoned the cycle: drop it without a strobe
            state <= ST_IDLE;
            busy  <= 1'b0;
            _wait <= 1'b1;
            wcnt  <= 4'd0;
          end else if (rise) begin
            if (wcnt != 4'd0) begin
              wcnt <= wcnt - 4'd1;
              if (wcnt == 4'd1) _wait <= 1'b1;
            end else begin
              case (state)
                ST_MEM: begin
                  // reads park here; a late _wr still gets its one strobe
                  if (!_wr) begin
                    ram_wr <= 1'b1;
                    state  <= ST_END;
                  end
                end
                ST_IO: begin
                  if (uart_hit) _uart_cs <= 1'b0;
                  state <= ST_END;
                end
                ST_INTA: state <= ST_END;
                default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  _wait <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// tb/tb_z80_bus_ctrl.sv - self-checking bench for z80_bus_ctrl (two parameter sets)
module tb_z80_bus_ctrl;

  localparam int PH_NONE = 0;
  localparam int PH_MEM  = 1;
  localparam int PH_IO   = 2;
  localparam int PH_INTA = 3;
  localparam int PH_DONE = 4;

  logic        eclk = 1'b0;
  logic        erst;
  logic        cpu_clk;
  logic        mreq_n, iorq_n, m1_n, rfsh_n, wr_n;
  logic [15:0] ab;

  logic       a_wait, a_ram_wr, a_cs, a_busy;
  logic [1:0] a_dsel;
  logic       b_wait, b_ram_wr, b_cs, b_busy;
  logic [1:0] b_dsel;

  int n_cmp = 0;
  int n_bad = 0;

  z80_bus_ctrl #(.UART_BASE(7'h55), .MEM_WAIT(2), .IO_WAIT(1)) dut_a (
    .eclk(eclk), .erst(erst), .cpu_clk(cpu_clk),
    ._mreq(mreq_n), ._iorq(iorq_n), ._m1(m1_n), ._rfsh(rfsh_n), ._wr(wr_n), .ab(ab),
    ._wait(a_wait), .ram_wr(a_ram_wr), ._uart_cs(a_cs), .dsel(a_dsel), .busy(a_busy)
  );

  z80_bus_ctrl #(.MEM_WAIT(0), .IO_WAIT(0)) dut_b (
    .eclk(eclk), .erst(erst), .cpu_clk(cpu_clk),
    ._mreq(mreq_n), ._iorq(iorq_n), ._m1(m1_n), ._rfsh(rfsh_n), ._wr(wr_n), .ab(ab),
    ._wait(b_wait), .ram_wr(b_ram_wr), ._uart_cs(b_cs), .dsel(b_dsel), .busy(b_busy)
  );

  always #5 eclk = ~eclk;

  // reference model: one entry per instance
  int         mw[2] = '{2, 0};
  int         iw[2] = '{1, 0};
  logic       m_last[2];
  int         m_ph[2];
  int         m_wc[2];
  logic       e_wait[2], e_wr[2], e_cs[2], e_busy[2];
  logic [1:0] e_dsel[2];

  typedef struct {
    logic c, mq, io, m1, rf, wr;
    logic [15:0] a;
    logic x_wait, x_wr, x_cs;
    logic [1:0] x_dsel;
    logic x_busy;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic rise, hit, quiet;
    for (int k = 0; k < 2; k++) begin
      if (erst) begin
        m_last[k] = 1'b0; m_ph[k] = PH_NONE; m_wc[k] = 0;
        e_wait[k] = 1'b1; e_wr[k] = 1'b0; e_cs[k] = 1'b1; e_dsel[k] = 2'd0; e_busy[k] = 1'b0;
      end else begin
        rise      = cpu_clk && !m_last[k];
        m_last[k] = cpu_clk;
        hit       = (ab[7:0] == 8'hAA) || (ab[7:0] == 8'hAB);
        quiet     = mreq_n && iorq_n;
        e_wr[k]   = 1'b0;
        e_cs[k]   = 1'b1;
        if (iorq_n)     e_dsel[k] = 2'd0;
        else if (!m1_n) e_dsel[k] = 2'd3;
        else if (hit)   e_dsel[k] = 2'd1;
        else            e_dsel[k] = 2'd2;
        case (m_ph[k])
          PH_NONE: if (rise) begin
            if (!mreq_n) begin
              if (rfsh_n) begin m_ph[k] = PH_MEM; m_wc[k] = mw[k]; end
            end else if (!iorq_n) begin
              if (m1_n) begin m_ph[k] = PH_IO; m_wc[k] = hit ? iw[k] : 0; end
              else begin m_ph[k] = PH_INTA; m_wc[k] = 0; end
            end
            if (m_ph[k] != PH_NONE) e_wait[k] = (m_wc[k] == 0);
          end
          PH_DONE: if (quiet) m_ph[k] = PH_NONE;
          default: begin
            if (quiet) begin
              m_ph[k] = PH_NONE; e_wait[k] = 1'b1;
            end else if (rise) begin
              if (m_wc[k] > 0) begin
                m_wc[k]--;
                e_wait[k] = (m_wc[k] == 0);
              end else if (m_ph[k] == PH_MEM) begin
                if (!wr_n) begin e_wr[k] = 1'b1; m_ph[k] = PH_DONE; end
              end else begin
                if (m_ph[k] == PH_IO && hit) e_cs[k] = 1'b0;
                m_ph[k] = PH_DONE;
              end
            end
          end
        endcase
        e_busy[k] = (m_ph[k] != PH_NONE);
      end
    end
  endtask

  task automatic chk_model();
    chk("mA_wait", a_wait, e_wait[0]);   chk("mB_wait", b_wait, e_wait[1]);
    chk("mA_ramwr", a_ram_wr, e_wr[0]);  chk("mB_ramwr", b_ram_wr, e_wr[1]);
    chk("mA_cs", a_cs, e_cs[0]);         chk("mB_cs", b_cs, e_cs[1]);
    chk("mA_dsel", a_dsel, e_dsel[0]);   chk("mB_dsel", b_dsel, e_dsel[1]);
    chk("mA_busy", a_busy, e_busy[0]);   chk("mB_busy", b_busy, e_busy[1]);
  endtask

  task automatic tick();
    @(posedge eclk);
    model_step();
    @(negedge eclk);
    chk_model();
  endtask

  task automatic drive(input logic c, mq, io, m1, rf, wr, input logic [15:0] a);
    cpu_clk = c; mreq_n = mq; iorq_n = io; m1_n = m1; rfsh_n = rf; wr_n = wr; ab = a;
  endtask

  task automatic add(input logic c, mq, io, m1, rf, wr, input logic [15:0] a,
                     input logic w, r, cs, input logic [1:0] d, input logic b);
    vec_t v;
    v.c = c; v.mq = mq; v.io = io; v.m1 = m1; v.rf = rf; v.wr = wr; v.a = a;
    v.x_wait = w; v.x_wr = r; v.x_cs = cs; v.x_dsel = d; v.x_busy = b;
    vt.push_back(v);
  endtask

  // write cycle with _mreq held low for several Z80 clocks, then one idle clock
  task automatic write_cycle(inout int pa, inout int pb);
    for (int i = 0; i < 24; i++) begin
      drive(i[1], 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000);
      tick();
      pa += int'(a_ram_wr); pb += int'(b_ram_wr);
    end
    for (int i = 0; i < 4; i++) begin
      drive(i[1], 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
      tick();
      pa += int'(a_ram_wr); pb += int'(b_ram_wr);
    end
  endtask

  initial begin
    int pa, pb;
    // memory read, MEM_WAIT=2 on instance A
    add(0,1,1,1,1,1,16'h0000, 1,0,1,0,0);
    add(1,0,1,1,1,1,16'h1234, 0,0,1,0,1);
    add(0,0,1,1,1,1,16'h1234, 0,0,1,0,1);
    add(1,0,1,1,1,1,16'h1234, 0,0,1,0,1);
    add(0,0,1,1,1,1,16'h1234, 0,0,1,0,1);
    add(1,0,1,1,1,1,16'h1234, 1,0,1,0,1);
    add(0,0,1,1,1,1,16'h1234, 1,0,1,0,1);
    add(1,0,1,1,1,1,16'h1234, 1,0,1,0,1);
    add(0,1,1,1,1,1,16'h0000, 1,0,1,0,0);
    // memory write
    add(1,1,1,1,1,1,16'h0000, 1,0,1,0,0);
    add(0,0,1,1,1,1,16'h2000, 1,0,1,0,0);
    add(1,0,1,1,1,1,16'h2000, 0,0,1,0,1);
    add(0,0,1,1,1,0,16'h2000, 0,0,1,0,1);
    add(1,0,1,1,1,0,16'h2000, 0,0,1,0,1);
    add(0,0,1,1,1,0,16'h2000, 0,0,1,0,1);
    add(1,0,1,1,1,0,16'h2000, 1,0,1,0,1);
    add(0,0,1,1,1,0,16'h2000, 1,0,1,0,1);
    add(1,0,1,1,1,0,16'h2000, 1,1,1,0,1);
    add(0,0,1,1,1,0,16'h2000, 1,0,1,0,1);
    add(1,0,1,1,1,0,16'h2000, 1,0,1,0,1);
    add(0,1,1,1,1,1,16'h0000, 1,0,1,0,0);
    // UART IO write, IO_WAIT=1
    add(1,1,1,1,1,1,16'h00AA, 1,0,1,0,0);
    add(0,1,0,1,1,0,16'h00AA, 1,0,1,1,0);
    add(1,1,0,1,1,0,16'h00AA, 0,0,1,1,1);
    add(0,1,0,1,1,0,16'h00AA, 0,0,1,1,1);
    add(1,1,0,1,1,0,16'h00AA, 1,0,1,1,1);
    add(0,1,0,1,1,0,16'h00AA, 1,0,1,1,1);
    add(1,1,0,1,1,0,16'h00AA, 1,0,0,1,1);
    add(0,1,0,1,1,0,16'h00AA, 1,0,1,1,1);
    add(0,1,1,1,1,1,16'h00AA, 1,0,1,0,0);
    // non-UART IO write
    add(1,1,1,1,1,1,16'h0010, 1,0,1,0,0);
    add(0,1,0,1,1,0,16'h0010, 1,0,1,2,0);
    add(1,1,0,1,1,0,16'h0010, 1,0,1,2,1);
    add(0,1,0,1,1,0,16'h0010, 1,0,1,2,1);
    add(1,1,0,1,1,0,16'h0010, 1,0,1,2,1);
    add(0,1,1,1,1,1,16'h0000, 1,0,1,0,0);
    // refresh
    add(1,0,1,1,0,1,16'h0000, 1,0,1,0,0);
    add(0,0,1,1,0,1,16'h0000, 1,0,1,0,0);
    add(1,0,1,1,0,1,16'h0000, 1,0,1,0,0);
    add(0,1,1,1,1,1,16'h0000, 1,0,1,0,0);
    // interrupt acknowledge
    add(1,1,0,0,1,1,16'h00AA, 1,0,1,3,1);
    add(0,1,0,0,1,1,16'h00AA, 1,0,1,3,1);
    add(1,1,0,0,1,1,16'h00AA, 1,0,1,3,1);
    add(0,1,1,1,1,1,16'h0000, 1,0,1,0,0);
    // early end while waiting
    add(1,0,1,1,1,1,16'h0000, 0,0,1,0,1);
    add(0,1,1,1,1,1,16'h0000, 1,0,1,0,0);
    // memory and IO requested together: memory wins
    add(1,0,0,1,1,1,16'h00AA, 0,0,1,1,1);
    add(0,1,1,1,1,1,16'h0000, 1,0,1,0,0);

    erst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    tick(); tick();
    chk("rst_wait", a_wait, 1'b1);
    chk("rst_ramwr", a_ram_wr, 1'b0);
    chk("rst_cs", a_cs, 1'b1);
    chk("rst_dsel", a_dsel, 2'd0);
    chk("rst_busy", a_busy, 1'b0);
    erst = 1'b0;
    tick();

    foreach (vt[i]) begin
      drive(vt[i].c, vt[i].mq, vt[i].io, vt[i].m1, vt[i].rf, vt[i].wr, vt[i].a);
      tick();
      chk($sformatf("row%0d_wait", i), a_wait, vt[i].x_wait);
      chk($sformatf("row%0d_ramwr", i), a_ram_wr, vt[i].x_wr);
      chk($sformatf("row%0d_cs", i), a_cs, vt[i].x_cs);
      chk($sformatf("row%0d_dsel", i), a_dsel, vt[i].x_dsel);
      chk($sformatf("row%0d_busy", i), a_busy, vt[i].x_busy);
    end

    // reset in the middle of a waited memory cycle
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h3000); tick();
    chk("mid_wait_low", a_wait, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h3000); tick();
    erst = 1'b1;
    tick();
    chk("mid_rst_wait", a_wait, 1'b1);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_ramwr", a_ram_wr, 1'b0);
    erst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000); tick();
    pa = 0; pb = 0;
    write_cycle(pa, pb);
    chk("post_rst_pulses_a", 16'(pa), 16'd1);
    chk("post_rst_pulses_b", 16'(pb), 16'd1);

    // back-to-back writes
    pa = 0; pb = 0;
    write_cycle(pa, pb);
    write_cycle(pa, pb);
    chk("b2b_pulses_a", 16'(pa), 16'd2);
    chk("b2b_pulses_b", 16'(pb), 16'd2);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      erst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) cpu_clk = ~cpu_clk;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          0: begin mreq_n = 1; iorq_n = 1; m1_n = 1; rfsh_n = 1; wr_n = 1; end
          1: begin mreq_n = 0; iorq_n = 1; m1_n = 1; rfsh_n = 1; wr_n = 1; end
          2: begin mreq_n = 0; iorq_n = 1; m1_n = 1; rfsh_n = 1; wr_n = 0; end
          3: begin mreq_n = 0; iorq_n = 1; m1_n = 1; rfsh_n = 0; wr_n = 1; end
          4: begin mreq_n = 1; iorq_n = 0; m1_n = 1; rfsh_n = 1; wr_n = 1'($urandom); end
          5: begin mreq_n = 1; iorq_n = 0; m1_n = 0; rfsh_n = 1; wr_n = 1; end
          default: begin mreq_n = 0; iorq_n = 0; m1_n = 1'($urandom); rfsh_n = 1'($urandom); wr_n = 1'($urandom); end
        endcase
        case ($urandom_range(0, 3))
          0: ab = 16'h00AA;
          1: ab = 16'h12AB;
          2: ab = 16'h0010;
          default: ab = 16'($urandom);
        endcase
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
